ifu_fetch: RTL and testbench

- Instruction fetch unit. Sits directly upstream of the single-cycle decode/execute datapath.
- Owns the architectural PC register and fetches instructions from instruction memory over a valid/ready request and valid-only response interface.
- Presents one instruction at a time to decode with a valid/ready handshake.
- Loads the downstream-computed next_pc when decode accepts the current instruction.

---
 rtl/ifu_fetch.sv | 108 ++++++++++
 tb/tb_ifu_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a valid/ready
// request channel and presents it to decode. Optional macro: IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic        fault_reg;
  logic        misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misaligned = (pc_reg[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (misaligned) begin
          state_next = S_HOLD;
        end else if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A faulting fetch presents a nop so decode never executes garbage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
      fault_reg <= 1'b0;
    end else begin
      if (state_reg == S_REQ && misaligned) begin
        inst_reg  <= NOP;
        fault_reg <= 1'b1;
      end
      if (state_reg == S_WAIT && imem_resp_valid) begin
        inst_reg  <= imem_resp_err ? NOP : imem_resp_data;
        fault_reg <= imem_resp_err;
      end
      if (state_reg == S_HOLD && inst_ready) begin
        pc_reg    <= next_pc;
        fault_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    imem_req_valid = (state_reg == S_REQ) && !misaligned;
    inst_valid     = (state_reg == S_HOLD);
    imem_addr      = pc_reg;
    pc             = pc_reg;
    inst           = inst_reg;
    fetch_fault    = fault_reg;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: transaction-level model checked every cycle,
// plus literal checkpoints along the stimulus sequence.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_fault;

  int total = 0;
  int bad = 0;
  int accepts = 0;
  bit chk_en = 1'b0;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .pc(pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: where the current fetch stands (fresh out of reset, asking memory,
  // awaiting data, or handing a word to decode), plus the architectural pc/inst/fault.
  bit          m_boot, m_asking, m_awaiting, m_presenting;
  logic [31:0] m_pc, m_inst;
  bit          m_fault;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_boot <= 1'b1; m_asking <= 1'b0; m_awaiting <= 1'b0; m_presenting <= 1'b0;
      m_pc <= RESET_PC; m_inst <= 32'h0; m_fault <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_asking <= 1'b1;
    end else if (m_asking) begin
      if (MIS_EN && (m_pc % 4 != 0)) begin
        m_asking <= 1'b0; m_presenting <= 1'b1; m_inst <= NOP; m_fault <= 1'b1;
      end else if (imem_req_ready) begin
        m_asking <= 1'b0; m_awaiting <= 1'b1;
      end
    end else if (m_awaiting) begin
      if (imem_resp_valid) begin
        m_awaiting <= 1'b0; m_presenting <= 1'b1;
        m_inst <= imem_resp_err ? NOP : imem_resp_data;
        m_fault <= imem_resp_err;
      end
    end else if (m_presenting) begin
      if (inst_ready) begin
        m_presenting <= 1'b0; m_asking <= 1'b1; m_pc <= next_pc; m_fault <= 1'b0;
      end
    end
  end

  // Compare process: outputs depend only on registered state, so sample at negedge.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("m_req_valid", {31'h0, imem_req_valid},
              {31'h0, m_asking && !(MIS_EN && (m_pc % 4 != 0))});
      check32("m_imem_addr", imem_addr, m_pc);
      check32("m_inst_valid", {31'h0, inst_valid}, {31'h0, m_presenting});
      check32("m_inst", inst, m_inst);
      check32("m_pc", pc, m_pc);
      check32("m_fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
      if (imem_req_valid && imem_req_ready) begin
        accepts++;
        $display("req  addr=%h", imem_addr);
      end
      if (inst_valid && inst_ready)
        $display("inst pc=%h inst=%h fault=%0d", pc, inst, fetch_fault);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int acc_base;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    chk_en = 1'b1;
    at_neg();
    check32("boot_bubble_req", {31'h0, imem_req_valid}, 32'h0);
    check32("boot_pc", pc, 32'h8000_0000);
    check32("boot_inst", inst, 32'h0);

    acc_base = accepts;
    for (int i = 0; i < 4; i++) begin
      cyc();
      at_neg();
      check32("bp_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check32("bp_addr", imem_addr, 32'h8000_0000);
    end
    cyc();
    imem_req_ready = 1'b1;
    at_neg();
    check32("bp_addr_accept", imem_addr, 32'h8000_0000);
    cyc();
    at_neg();
    check32("wait_req_low", {31'h0, imem_req_valid}, 32'h0);
    cyc();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0050_0093;
    next_pc = 32'h8000_0004;
    cyc();
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    check32("one_accept", accepts - acc_base, 32'd1);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check32("hold_valid", {31'h0, inst_valid}, 32'h1);
      check32("hold_inst", inst, 32'h0050_0093);
      check32("hold_pc", pc, 32'h8000_0000);
      cyc();
    end
    inst_ready = 1'b1;
    at_neg();
    check32("hs_pc_before", pc, 32'h8000_0000);
    cyc();
    inst_ready = 1'b0;
    at_neg();
    check32("seq_pc", pc, 32'h8000_0004);
    check32("seq_addr_valid", {31'h0, imem_req_valid}, 32'h1);

    // Jump redirect; inst_ready raised while still waiting on memory
    cyc();
    inst_ready = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0400_006f;
    at_neg();
    check32("wait_ignores_ready", {31'h0, inst_valid}, 32'h0);
    cyc();
    imem_resp_valid = 1'b0;
    next_pc = 32'h8000_0100;
    at_neg();
    check32("jump_inst", inst, 32'h0400_006f);
    check32("jump_pc", pc, 32'h8000_0004);
    cyc();
    inst_ready = 1'b0;
    at_neg();
    check32("jump_addr", imem_addr, 32'h8000_0100);

    // Access fault
    cyc();
    imem_resp_valid = 1'b1;
    imem_resp_err = 1'b1;
    imem_resp_data = 32'hdead_beef;
    cyc();
    imem_resp_valid = 1'b0;
    imem_resp_err = 1'b0;
    inst_ready = 1'b1;
    next_pc = 32'h8000_0104;
    at_neg();
    check32("fault_inst", inst, NOP);
    check32("fault_flag", {31'h0, fetch_fault}, 32'h1);
    cyc();
    inst_ready = 1'b0;
    at_neg();
    check32("fault_cleared", {31'h0, fetch_fault}, 32'h0);
    check32("fault_next_addr", imem_addr, 32'h8000_0104);

    // Asynchronous reset while waiting on memory; stale response after release
    cyc();
    at_neg();
    #2;
    rst = 1'b0;
    #1;
    check32("async_rst_pc", pc, RESET_PC);
    check32("async_rst_inst", inst, 32'h0);
    check32("async_rst_req", {31'h0, imem_req_valid}, 32'h0);
    cyc();
    rst = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h1111_1111;
    at_neg();
    check32("rst_idle_req", {31'h0, imem_req_valid}, 32'h0);
    cyc();
    imem_resp_valid = 1'b0;
    at_neg();
    check32("rst_stale_ignored", {31'h0, inst_valid}, 32'h0);
    check32("rst_restart_req", {31'h0, imem_req_valid}, 32'h1);
    check32("rst_restart_addr", imem_addr, RESET_PC);

    // Misaligned next_pc
    cyc();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0010_0113;
    cyc();
    imem_resp_valid = 1'b0;
    inst_ready = 1'b1;
    next_pc = 32'h8000_0002;
    cyc();
    inst_ready = 1'b0;
    next_pc = 32'h8000_0008;
    at_neg();
    check32("mis_pc", pc, 32'h8000_0002);
`ifdef IFU_MISALIGN_CHECK_EN
    check32("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
    cyc();
    at_neg();
    check32("mis_valid", {31'h0, inst_valid}, 32'h1);
    check32("mis_fault", {31'h0, fetch_fault}, 32'h1);
    check32("mis_inst", inst, NOP);
    cyc();
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
`else
    check32("mis_req_issued", {31'h0, imem_req_valid}, 32'h1);
    check32("mis_addr", imem_addr, 32'h8000_0002);
    cyc();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0020_0193;
    cyc();
    imem_resp_valid = 1'b0;
    at_neg();
    check32("mis_plain_inst", inst, 32'h0020_0193);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
`endif
    at_neg();
    check32("final_addr", imem_addr, 32'h8000_0008);
    repeat (4) cyc();
    at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
